// File: rtl/st7735_init_sequencer.sv
// ST7735 bring-up sequencer: pulses the panel reset, waits, then walks a command ROM
// issuing CMD/DATA bytes over a valid/ready handshake with embedded millisecond delays.
module st7735_init_sequencer #(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int ROM_AW          = 6,
    parameter int RESET_PULSE_US  = 10,
    parameter int RESET_WAIT_MS   = 120
) (
    input  logic              SYSTEM_CLK,
    input  logic              SYSTEM_RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              LCD_RST_N,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [7:0]        byte_data,
    output logic              byte_dc
);

    // Byte handshake: byte_valid/byte_data/byte_dc are held until a rising edge sees
    // byte_valid && byte_ready; byte_ready while byte_valid is low is ignored.
    localparam int                MS_CYCLES  = CLOCK_SPEED_MHZ * 1000;
    localparam int                PW         = $clog2(MS_CYCLES);
    localparam logic [PW-1:0]     MS_LAST    = PW'(MS_CYCLES - 1);
    localparam logic [PW-1:0]     PULSE_LAST = PW'(RESET_PULSE_US * CLOCK_SPEED_MHZ - 1);
    localparam logic [7:0]        WAIT_MS    = 8'(RESET_WAIT_MS);
    localparam logic [ROM_AW-1:0] LAST_ADDR  = '1;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_DECODE,
        S_SEND, S_DELAY, S_ADVANCE, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [PW-1:0]     presc, next_presc;
    logic [7:0]        ms_left, next_ms_left;
    logic [ROM_AW-1:0] next_rom_addr;
    logic              next_busy, next_done, next_err, next_lcd_rst_n;
    logic              next_byte_valid, next_byte_dc;
    logic [7:0]        next_byte_data;

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RST) begin
            state      <= S_IDLE;
            presc      <= '0;
            ms_left    <= '0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            LCD_RST_N  <= 1'b1;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            state      <= next_state;
            presc      <= next_presc;
            ms_left    <= next_ms_left;
            rom_addr   <= next_rom_addr;
            busy       <= next_busy;
            done       <= next_done;
            err        <= next_err;
            LCD_RST_N  <= next_lcd_rst_n;
            byte_valid <= next_byte_valid;
            byte_data  <= next_byte_data;
            byte_dc    <= next_byte_dc;
        end
    end

    always_comb begin
        next_state      = state;
        next_presc      = presc;
        next_ms_left    = ms_left;
        next_rom_addr   = rom_addr;
        next_busy       = busy;
        next_done       = done;
        next_err        = err;
        next_lcd_rst_n  = LCD_RST_N;
        next_byte_valid = byte_valid;
        next_byte_data  = byte_data;
        next_byte_dc    = byte_dc;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state     = S_RST_LOW;
                    next_busy      = 1'b1;
                    next_done      = 1'b0;
                    next_err       = 1'b0;
                    next_rom_addr  = '0;
                    next_lcd_rst_n = 1'b0;
                    next_presc     = '0;
                end
            end
            S_RST_LOW: begin
                if (presc == PULSE_LAST) begin
                    next_lcd_rst_n = 1'b1;
                    next_presc     = '0;
                    next_ms_left   = WAIT_MS;
                    next_state     = (WAIT_MS == 8'd0) ? S_FETCH : S_RST_WAIT;
                end else begin
                    next_presc = presc + 1'b1;
                end
            end
            // Both waits share the prescaler; it is zeroed on entry so each ms is whole.
            S_RST_WAIT, S_DELAY: begin
                if (presc == MS_LAST) begin
                    next_presc   = '0;
                    next_ms_left = ms_left - 8'd1;
                    if (ms_left == 8'd1) begin
                        next_state = (state == S_RST_WAIT) ? S_FETCH : S_ADVANCE;
                    end
                end else begin
                    next_presc = presc + 1'b1;
                end
            end
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (rom_data[9:8])
                    OP_CMD, OP_DATA: begin
                        next_byte_valid = 1'b1;
                        next_byte_data  = rom_data[7:0];
                        next_byte_dc    = rom_data[8];
                        next_state      = S_SEND;
                    end
                    OP_DELAY: begin
                        if (rom_data[7:0] != 8'd0) begin
                            next_ms_left = rom_data[7:0];
                            next_presc   = '0;
                            next_state   = S_DELAY;
                        end else begin
                            next_state = S_ADVANCE;
                        end
                    end
                    default: begin
                        next_busy  = 1'b0;
                        next_done  = 1'b1;
                        next_state = S_DONE;
                    end
                endcase
            end
            S_SEND: begin
                if (byte_ready) begin
                    next_byte_valid = 1'b0;
                    next_state      = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (rom_addr == LAST_ADDR) begin
                    next_err   = 1'b1;
                    next_done  = 1'b1;
                    next_busy  = 1'b0;
                    next_state = S_DONE;
                end else begin
                    next_rom_addr = rom_addr + 1'b1;
                    next_state    = S_FETCH;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_st7735_init_sequencer.sv
// Bench for st7735_init_sequencer: a ROM-walking model predicts the byte stream, offer
// timing, reset pulse and final flags; one negedge process compares every cycle.
module tb_st7735_init_sequencer;

    localparam int MHZ = 1, AW = 2, PULSE = 10, WAIT = 1, MS = MHZ * 1000;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, byte_ready = 1'b0;
    logic          busy, done, err, lcd_rst_n, byte_valid, byte_dc;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic [7:0]    byte_data;
    logic [9:0]    rom_mem [4];

    st7735_init_sequencer #(
        .CLOCK_SPEED_MHZ(MHZ), .ROM_AW(AW), .RESET_PULSE_US(PULSE), .RESET_WAIT_MS(WAIT)
    ) dut (
        .SYSTEM_CLK(clk), .SYSTEM_RST(rst), .start(start), .busy(busy), .done(done),
        .err(err), .LCD_RST_N(lcd_rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .byte_dc(byte_dc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int total = 0, bad = 0;
    logic [8:0] exp_q[$];
    int gap_q[$], tol_q[$];
    logic exp_err;
    logic [AW-1:0] exp_addr;
    int cyc = 0, last_event = 0, low_cnt = 0, pulses = 0, hs_cnt = 0, first_gap = -1;
    int valid_age = 0, ready_mode = 0, ready_pct = 100, run_pulses = 0, run_hs = 0;
    bit run_active = 1'b0;
    logic prev_valid = 1'b0, prev_rst_n = 1'b1, prev_hs = 1'b0, prev_dc = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Walk the ROM as the panel would see it: bytes in order, gaps between offers.
    task automatic build_model();
        int g, t;
        logic [1:0] op;
        logic [7:0] arg;
        exp_q.delete(); gap_q.delete(); tol_q.delete();
        g = WAIT * MS + 2; t = 2;
        exp_err = 1'b1; exp_addr = AW'(3);
        for (int i = 0; i < 4; i++) begin
            op = rom_mem[i][9:8]; arg = rom_mem[i][7:0];
            if (op == 2'b11) begin
                exp_err = 1'b0; exp_addr = AW'(i);
                break;
            end else if (op == 2'b10) begin
                g += int'(arg) * MS + 3; t += 2;
            end else begin
                exp_q.push_back({op[0], arg}); gap_q.push_back(g); tol_q.push_back(t);
                g = 4; t = 0;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rst_n"}, lcd_rst_n, 1);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_valid"}, byte_valid, 0);
        check({tag, "_data"}, byte_data, 0);
        check({tag, "_dc"}, byte_dc, 0);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (!lcd_rst_n) low_cnt++;
            if (lcd_rst_n && !prev_rst_n) begin
                check("rst_low_cycles", low_cnt, PULSE);
                low_cnt = 0; pulses++; last_event = cyc;
            end
            if (run_active && !done) check("busy_during_run", busy, 1);
            if (done) check("busy_in_done", busy, 0);
            if (byte_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_byte: got data=%h dc=%0d, required no offer", byte_data, byte_dc);
                end else begin
                    if (first_gap < 0) first_gap = cyc - last_event;
                    check_range("offer_gap", cyc - last_event, gap_q[0] - tol_q[0], gap_q[0] + tol_q[0]);
                    check("byte_data", byte_data, exp_q[0][7:0]);
                    check("byte_dc", byte_dc, exp_q[0][8]);
                end
            end
            if (byte_valid && prev_valid && !prev_hs) begin
                check("hold_data", byte_data, prev_data);
                check("hold_dc", byte_dc, prev_dc);
            end
            valid_age = byte_valid ? valid_age + 1 : 0;
            case (ready_mode)
                1: byte_ready = (valid_age >= 8);
                2: byte_ready = 1'b0;
                default: byte_ready = ($urandom_range(0, 99) < ready_pct);
            endcase
            prev_hs = byte_valid && byte_ready;
            if (prev_hs && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(gap_q.pop_front()); void'(tol_q.pop_front());
                hs_cnt++; last_event = cyc;
            end
            prev_valid = byte_valid; prev_rst_n = lcd_rst_n;
            prev_data = byte_data; prev_dc = byte_dc;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic run_seq(input int mode, input int pct, input int extra_start);
        int n;
        ready_mode = mode; ready_pct = pct;
        build_model();
        run_pulses = pulses; run_hs = hs_cnt; first_gap = -1; low_cnt = 0;
        pulse_start();
        run_active = 1'b1;
        @(negedge clk);
        check("addr_after_start", rom_addr, 0);
        check("rst_n_after_start", lcd_rst_n, 0);
        check("done_cleared", done, 0);
        check("err_cleared", err, 0);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            start = (n == extra_start);
        end
        start = 1'b0;
        run_active = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", n);
        end
        check("err_final", err, exp_err);
        check("addr_final", rom_addr, exp_addr);
        check("queue_drained", exp_q.size(), 0);
        check("reset_pulses", pulses - run_pulses, 1);
        repeat (12) @(negedge clk);
        check("done_hold", done, 1);
        check("valid_idle", byte_valid, 0);
        check("addr_hold", rom_addr, exp_addr);
    endtask

    task automatic load_basic();
        rom_mem[0] = {2'b00, 8'h11}; rom_mem[1] = {2'b01, 8'hA5};
        rom_mem[2] = {2'b11, 8'h00}; rom_mem[3] = {2'b11, 8'h00};
    endtask

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        load_basic();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("idle");

        // Basic sequence, ready always high.
        run_seq(0, 100, 0);
        check("basic_handshakes", hs_cnt - run_hs, 2);
        check_range("basic_first_offer", first_gap, 1000, 1004);

        // Backpressure: ready low for 7 cycles of each offer.
        run_seq(1, 100, 0);
        check("bp_handshakes", hs_cnt - run_hs, 2);

        // Delay ops.
        rom_mem[0] = {2'b10, 8'd3}; rom_mem[1] = {2'b00, 8'h29};
        rom_mem[2] = {2'b10, 8'd0}; rom_mem[3] = {2'b11, 8'h00};
        run_seq(0, 100, 0);
        check_range("delay_first_offer", first_gap, 3993, 4009);
        check("delay_handshakes", hs_cnt - run_hs, 1);

        // Missing END: every entry is a command.
        for (int i = 0; i < 4; i++) rom_mem[i] = {2'b00, 8'(i + 1)};
        run_seq(0, 100, 0);
        check("noend_handshakes", hs_cnt - run_hs, 4);
        check("noend_err", err, 1);

        // start while busy: once during the post-reset wait, once around the first offer.
        load_basic();
        run_seq(0, 100, 100);
        run_seq(1, 100, 1015);

        // Reset during a held offer.
        ready_mode = 2;
        build_model();
        pulse_start();
        run_active = 1'b1;
        n = 0;
        while (!byte_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!byte_valid) begin
            total++; bad++;
            $display("FAIL offer_timeout: got byte_valid=0, required an offer");
        end
        rst = 1'b1; run_active = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        #1;
        rst = 1'b0;
        exp_q.delete(); gap_q.delete(); tol_q.delete();
        repeat (3) @(negedge clk);
        check_reset_values("abort_idle");
        run_seq(0, 100, 0);
        check("rerun_handshakes", hs_cnt - run_hs, 2);

        // Randomised ROM contents and ready behaviour.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                logic [1:0] op;
                op = 2'($urandom_range(0, 3));
                rom_mem[i] = {op, (op == 2'b10) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255))};
            end
            run_seq(0, $urandom_range(30, 100), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
